// File: rtl/shader_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : shader_program_loader
// Purpose  : Upstream feeder for shader_memory. Takes decoded SPI bytes,
//            queues instruction (data) bytes in a FIFO, and replays exactly
//            NUM_INSTR of them to shader_memory as one uninterrupted burst
//            that may only start during vertical blanking, so the program
//            never changes mid-frame. Command bytes drive a small user
//            register file and the arm/clear controls.
// Ports    : clk_i, rst_ni        clock, synchronous active-low reset
//            byte_i, byte_valid_i SPI byte and its one-cycle strobe
//            mode_i               0 = command byte, 1 = instruction byte
//            vblank_i             vertical blanking window
//            memory_instr_o       instruction presented to shader_memory
//            memory_shift_o       shift strobe (high during the burst)
//            memory_load_o        load strobe (high during the burst)
//            registers_o          user registers, reg n at [n*REG_SIZE +: REG_SIZE]
//            busy_o               burst in progress
//            armed_o              load requested, waiting for vblank/data
//            overflow_o           sticky, an instruction byte was dropped
//            program_done_o       one-cycle pulse after a burst
// Revision : 1.0 - initial release
// ============================================================================
module shader_program_loader #(
  parameter int NUM_INSTR  = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_REGS   = 2,
  parameter int REG_SIZE   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [7:0]                   byte_i,
  input  logic                         byte_valid_i,
  input  logic                         mode_i,
  input  logic                         vblank_i,
  output logic [7:0]                   memory_instr_o,
  output logic                         memory_shift_o,
  output logic                         memory_load_o,
  output logic [NUM_REGS*REG_SIZE-1:0] registers_o,
  output logic                         busy_o,
  output logic                         armed_o,
  output logic                         overflow_o,
  output logic                         program_done_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;

  localparam logic [7:0]        CMD_CLEAR = 8'h80;
  localparam logic [7:0]        CMD_ARM   = 8'hC0;
  localparam logic [CNT_W-1:0]  C_DEPTH   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  C_NINSTR  = CNT_W'(NUM_INSTR);
  localparam logic [BEAT_W-1:0] C_LAST    = BEAT_W'(NUM_INSTR - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [7:0]                   fifo_mem_q [FIFO_DEPTH];
  logic [7:0]                   fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic                         armed_q, armed_d;
  logic                         overflow_q, overflow_d;
  logic                         reg_pend_q, reg_pend_d;
  logic [5:0]                   reg_idx_q, reg_idx_d;
  logic [NUM_REGS*REG_SIZE-1:0] registers_q, registers_d;
  logic [7:0]                   instr_q, instr_d;
  logic                         strobe_q, strobe_d;
  logic                         done_q, done_d;

  logic is_data;
  logic is_cmd;
  logic fifo_full;
  logic start;
  logic push;
  logic pop;

  always_comb begin
    state_d     = state_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    beat_d      = beat_q;
    armed_d     = armed_q;
    overflow_d  = overflow_q;
    reg_pend_d  = reg_pend_q;
    reg_idx_d   = reg_idx_q;
    registers_d = registers_q;
    instr_d     = instr_q;
    strobe_d    = 1'b0;
    done_d      = 1'b0;

    is_data   = byte_valid_i & mode_i;
    is_cmd    = byte_valid_i & ~mode_i;
    // Full is judged on the count before this cycle's pop.
    fifo_full = (count_q == C_DEPTH);
    start     = (state_q == ST_IDLE) & armed_q & vblank_i & (count_q >= C_NINSTR);
    // The first beat is popped on the transition edge so the head shows up
    // registered together with the strobes on the first LOAD cycle.
    pop       = start | ((state_q == ST_LOAD) & (beat_q != C_LAST));
    push      = is_data & ~fifo_full;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          strobe_d = 1'b1;
          beat_d   = '0;
          armed_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (beat_q != C_LAST) begin
          beat_d   = beat_q + BEAT_W'(1);
          strobe_d = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop) begin
      instr_d  = fifo_mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      fifo_mem_d[wr_ptr_q] = byte_i;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (is_data) begin
      // An instruction byte aborts any half-finished register write.
      reg_pend_d = 1'b0;
      if (fifo_full) begin
        overflow_d = 1'b1;
      end
    end

    if (is_cmd) begin
      if (reg_pend_q) begin
        reg_pend_d = 1'b0;
        for (int n = 0; n < NUM_REGS; n++) begin
          if (reg_idx_q == 6'(n)) begin
            registers_d[n*REG_SIZE +: REG_SIZE] = REG_SIZE'(byte_i);
          end
        end
      end else if (byte_i[7:6] == 2'b01) begin
        reg_pend_d = 1'b1;
        reg_idx_d  = byte_i[5:0];
      end else if (byte_i == CMD_CLEAR) begin
        // No pop can be in flight here: the flush is blocked both during the
        // burst and on the edge that launches it.
        if (!strobe_q && !start) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          armed_d    = 1'b0;
        end
      end else if (byte_i == CMD_ARM) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      armed_q     <= 1'b0;
      overflow_q  <= 1'b0;
      reg_pend_q  <= 1'b0;
      reg_idx_q   <= '0;
      registers_q <= '0;
      instr_q     <= '0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      armed_q     <= armed_d;
      overflow_q  <= overflow_d;
      reg_pend_q  <= reg_pend_d;
      reg_idx_q   <= reg_idx_d;
      registers_q <= registers_d;
      instr_q     <= instr_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
    end
  end

  assign memory_instr_o = instr_q;
  assign memory_shift_o = strobe_q;
  assign memory_load_o  = strobe_q;
  assign busy_o         = strobe_q;
  assign registers_o    = registers_q;
  assign armed_o        = armed_q;
  assign overflow_o     = overflow_q;
  assign program_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shader_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_shader_program_loader
// Purpose  : Directed self-checking bench for shader_program_loader. Data
//            bytes are pushed into a model FIFO queue when driven; every
//            load-strobe cycle pops the queue and compares the instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shader_program_loader;

  localparam int NUM_INSTR  = 12;
  localparam int FIFO_DEPTH = 16;
  localparam int NUM_REGS   = 2;
  localparam int REG_SIZE   = 8;

  logic                         clk_i = 1'b0;
  logic                         rst_ni;
  logic [7:0]                   byte_i;
  logic                         byte_valid_i;
  logic                         mode_i;
  logic                         vblank_i;
  logic [7:0]                   memory_instr_o;
  logic                         memory_shift_o;
  logic                         memory_load_o;
  logic [NUM_REGS*REG_SIZE-1:0] registers_o;
  logic                         busy_o;
  logic                         armed_o;
  logic                         overflow_o;
  logic                         program_done_o;

  int total = 0;
  int bad = 0;
  int load_cycles = 0;
  int done_pulses = 0;
  logic [7:0] exp_q[$];

  shader_program_loader #(
    .NUM_INSTR (NUM_INSTR),
    .FIFO_DEPTH(FIFO_DEPTH),
    .NUM_REGS  (NUM_REGS),
    .REG_SIZE  (REG_SIZE)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .mode_i        (mode_i),
    .vblank_i      (vblank_i),
    .memory_instr_o(memory_instr_o),
    .memory_shift_o(memory_shift_o),
    .memory_load_o (memory_load_o),
    .registers_o   (registers_o),
    .busy_o        (busy_o),
    .armed_o       (armed_o),
    .overflow_o    (overflow_o),
    .program_done_o(program_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each load-strobe cycle must carry the oldest queued byte.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (memory_load_o) begin
        load_cycles++;
        total++;
        assert (exp_q.size() != 0)
        else begin
          bad++;
          $error("FAIL sb_underflow: observed=load strobe expected=empty model queue idle");
        end
        if (exp_q.size() != 0) begin
          chk("instr", {24'd0, memory_instr_o}, {24'd0, exp_q.pop_front()});
        end
        chk("shift", {31'd0, memory_shift_o}, 32'd1);
      end
      if (program_done_o) begin
        done_pulses++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic m, input logic [7:0] b);
    byte_i       = b;
    mode_i       = m;
    byte_valid_i = 1'b1;
    if (m && exp_q.size() < FIFO_DEPTH) begin
      exp_q.push_back(b);
    end
    tick();
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    mode_i       = 1'b0;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      send(1'b1, first + 8'(i));
    end
  endtask

  // ARM, then one cycle of vblank; the burst must start on the next edge.
  task automatic trigger_burst();
    load_cycles = 0;
    done_pulses = 0;
    send(1'b0, 8'hC0);
    vblank_i = 1'b1;
    tick();
    chk("load_start", {31'd0, memory_load_o}, 32'd1);
    vblank_i = 1'b0;
  endtask

  task automatic finish_burst(input int left);
    repeat (16) tick();
    chk("burst_len", load_cycles, NUM_INSTR);
    chk("done_pulse", done_pulses, 1);
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
    chk("load_idle", {31'd0, memory_load_o}, 32'd0);
    chk("sb_left", exp_q.size(), left);
  endtask

  initial begin
    rst_ni       = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    mode_i       = 1'b0;
    vblank_i     = 1'b0;
    repeat (3) tick();
    chk("rst_load", {31'd0, memory_load_o}, 32'd0);
    chk("rst_shift", {31'd0, memory_shift_o}, 32'd0);
    chk("rst_instr", {24'd0, memory_instr_o}, 32'd0);
    chk("rst_regs", {16'd0, registers_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_armed", {31'd0, armed_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    chk("rst_done", {31'd0, program_done_o}, 32'd0);
    rst_ni = 1'b1;
    tick();

    // Basic burst with vblank held high.
    vblank_i = 1'b1;
    push_seq(8'h01, 12);
    chk("t1_no_load_unarmed", {31'd0, memory_load_o}, 32'd0);
    load_cycles = 0;
    done_pulses = 0;
    send(1'b0, 8'hC0);
    chk("t1_armed", {31'd0, armed_o}, 32'd1);
    tick();
    chk("t1_load_start", {31'd0, memory_load_o}, 32'd1);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    chk("t1_armed_clr", {31'd0, armed_o}, 32'd0);
    finish_burst(0);
    chk("t1_instr_hold", {24'd0, memory_instr_o}, 32'h0C);

    // Armed with 11 bytes: waits; the 12th byte releases it.
    push_seq(8'h31, 11);
    load_cycles = 0;
    done_pulses = 0;
    send(1'b0, 8'hC0);
    repeat (4) tick();
    chk("t2_no_load_11", {31'd0, memory_load_o}, 32'd0);
    chk("t2_still_armed", {31'd0, armed_o}, 32'd1);
    send(1'b1, 8'h3C);
    chk("t2_not_yet", {31'd0, memory_load_o}, 32'd0);
    tick();
    chk("t2_load_start", {31'd0, memory_load_o}, 32'd1);
    finish_burst(0);

    // No vblank: no strobes; a 2-cycle vblank still yields a full burst.
    vblank_i = 1'b0;
    push_seq(8'h21, 12);
    load_cycles = 0;
    done_pulses = 0;
    send(1'b0, 8'hC0);
    repeat (5) tick();
    chk("t3_no_load_noblank", {31'd0, memory_load_o}, 32'd0);
    vblank_i = 1'b1;
    tick();
    chk("t3_load_start", {31'd0, memory_load_o}, 32'd1);
    tick();
    vblank_i = 1'b0;
    finish_burst(0);

    // Overflow: 17 bytes into 16 entries, byte 0x50 is lost.
    push_seq(8'h40, 17);
    chk("t4_overflow", {31'd0, overflow_o}, 32'd1);
    trigger_burst();
    finish_burst(4);
    chk("t4_ovf_sticky", {31'd0, overflow_o}, 32'd1);
    push_seq(8'h51, 8);
    trigger_burst();
    finish_burst(0);
    push_seq(8'h61, 5);
    send(1'b0, 8'h80);
    exp_q.delete();
    chk("t4_clear_ovf", {31'd0, overflow_o}, 32'd0);
    send(1'b0, 8'hC0);
    vblank_i = 1'b1;
    repeat (4) tick();
    chk("t4_cleared_no_load", {31'd0, memory_load_o}, 32'd0);
    vblank_i = 1'b0;
    send(1'b0, 8'h80);
    chk("t4_clear_disarm", {31'd0, armed_o}, 32'd0);
    push_seq(8'h71, 12);
    trigger_burst();
    finish_burst(0);

    // Register file writes, out-of-range index, cancel by data byte.
    send(1'b0, 8'h41);
    send(1'b0, 8'h5A);
    chk("t5_reg1", {16'd0, registers_o}, 32'h5A00);
    send(1'b0, 8'h45);
    send(1'b0, 8'h33);
    chk("t5_reg_oob", {16'd0, registers_o}, 32'h5A00);
    send(1'b0, 8'h40);
    send(1'b1, 8'h77);
    chk("t5_reg_cancel", {16'd0, registers_o}, 32'h5A00);
    send(1'b0, 8'h40);
    send(1'b0, 8'hA5);
    chk("t5_reg0", {16'd0, registers_o}, 32'h5AA5);

    // 13 queued; CLEAR during the burst is ignored, ARM re-arms.
    push_seq(8'h81, 12);
    trigger_burst();
    tick();
    send(1'b0, 8'h80);
    send(1'b0, 8'hC0);
    finish_burst(1);
    chk("t5_rearmed", {31'd0, armed_o}, 32'd1);
    vblank_i    = 1'b1;
    load_cycles = 0;
    done_pulses = 0;
    push_seq(8'h91, 11);
    finish_burst(0);
    vblank_i = 1'b0;

    // Reset on the 5th burst cycle.
    push_seq(8'hB1, 12);
    trigger_burst();
    repeat (4) tick();
    rst_ni = 1'b0;
    exp_q.delete();
    tick();
    chk("t6_load", {31'd0, memory_load_o}, 32'd0);
    chk("t6_shift", {31'd0, memory_shift_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_instr", {24'd0, memory_instr_o}, 32'd0);
    chk("t6_regs", {16'd0, registers_o}, 32'd0);
    chk("t6_done", {31'd0, program_done_o}, 32'd0);
    rst_ni   = 1'b1;
    vblank_i = 1'b1;
    send(1'b0, 8'hC0);
    repeat (4) tick();
    chk("t6_fifo_empty", {31'd0, memory_load_o}, 32'd0);
    load_cycles = 0;
    done_pulses = 0;
    push_seq(8'hC1, 12);
    finish_burst(0);
    vblank_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shader_program_loader.md
Name: shader_program_loader

Overview:
Upstream feeder for shader_memory. Accepts decoded SPI bytes plus the command/data mode flag, buffers instruction bytes in a FIFO, and drives the memory load interface (memory_instr_o, memory_shift_o, memory_load_o) as one atomic burst of NUM_INSTR instructions, only during vertical blanking. This keeps the program from changing mid-frame. Also owns the user register file (registers_o) written via command bytes.

Parameters:
NUM_INSTR, 12, instructions per program; length of one load burst
FIFO_DEPTH, 16, instruction FIFO entries (power of two, >= NUM_INSTR)
NUM_REGS, 2, number of user registers
REG_SIZE, 8, bits per user register

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
byte_i  input  8  received SPI byte
byte_valid_i  input  1  one-cycle strobe; byte_i and mode_i are valid
mode_i  input  1  0 = command byte, 1 = data (instruction) byte
vblank_i  input  1  vertical blanking from timing_ver
memory_instr_o  output  8  instruction to shader_memory
memory_shift_o  output  1  shift strobe to shader_memory
memory_load_o  output  1  load strobe to shader_memory
registers_o  output  NUM_REGS*REG_SIZE  user registers; reg n at [n*REG_SIZE +: REG_SIZE]
busy_o  output  1  high while a load burst is in progress
armed_o  output  1  load requested and pending
overflow_o  output  1  sticky; a data byte was dropped on a full FIFO
program_done_o  output  1  one-cycle pulse after a burst completes

Behaviour:
- Interface: one clock clk_i; reset rst_ni is synchronous and active-low. All state resets on the clk_i edge when rst_ni=0.
- Reset values: every output is 0, the FIFO is empty, the FSM is in IDLE, and there is no pending register write.
- Data byte (mode_i=1): pushed to the FIFO. If the FIFO is full, the byte is dropped and overflow_o is set. The count is visible the cycle after the strobe.
- Data byte arriving while a register write is pending: cancels the pending write, then is handled as data.
- Command byte (mode_i=0) with no register write pending:
  - 0b01iiiiii = WRITE_REG. The next command byte is the value for register i. If i >= NUM_REGS, the value is consumed and discarded.
  - 0x80 = CLEAR. Flushes the FIFO and clears overflow_o and armed. Ignored while busy_o=1.
  - 0xC0 = ARM. Sets armed_o.
  - All other codes are NOP.
- Register update: registers_o changes the cycle after the value byte's strobe.
- FSM IDLE -> LOAD when armed_o=1, vblank_i=1, and fifo_count >= NUM_INSTR, all in the same cycle. On that transition armed_o clears.
- LOAD: for exactly NUM_INSTR consecutive cycles, starting the cycle after the transition:
  - memory_load_o=1 and memory_shift_o=1;
  - memory_instr_o = FIFO head, registered, in FIFO order;
  - one pop per cycle.
- LOAD completion: runs to completion even if vblank_i falls mid-burst. busy_o=1 for exactly those cycles.
- LOAD -> DONE: program_done_o=1 for one cycle, then IDLE. memory_instr_o holds its last value; the strobes are 0 outside LOAD.
- Pushes during LOAD are accepted. A simultaneous push and pop leaves the count unchanged. Full is judged before the pop in that cycle, so a push on a full FIFO is dropped even if a pop occurs.
- ARM received during LOAD re-arms for the next burst. Leftover bytes (count > NUM_INSTR) remain for the next burst.
- FIFO pointers wrap modulo FIFO_DEPTH. The count saturates at FIFO_DEPTH.
- Reset mid-LOAD: the burst is abandoned and all strobes drop on the reset edge.

Test Plan:
- Push 12 data bytes 0x01..0x0C, send ARM, hold vblank_i=1 -> memory_load_o high for 12 cycles with instr 0x01..0x0C in order; program_done_o pulses once; busy_o low afterwards.
- ARM with 11 bytes queued, vblank_i=1 -> no load. Push a 12th byte -> burst starts the cycle after the count reaches 12.
- 12 bytes queued, armed, vblank_i=0 -> no strobes. Raise vblank_i for 2 cycles only -> the full 12-cycle burst still completes.
- Push 17 bytes into the 16-deep FIFO -> overflow_o=1 and byte 17 is lost. CLEAR -> count 0, overflow_o=0.
- Command bytes 0x41, 0x5A -> registers_o[15:8]=0x5A. Bytes 0x45, 0x33 -> no register changes. Bytes 0x40 then data 0x77 -> reg0 unchanged and 0x77 enters the FIFO.
- Assert rst_ni=0 on the 5th cycle of a burst -> all strobes and outputs are 0 on the next edge and the FIFO is empty.
